// File: rtl/coef_pingpong_ram.sv
// Ping-pong coefficient RAM: the host fills the shadow page while the filter reads the active page.
// Swaps land on frame boundaries. Define COEF_RAM_READBACK_EN to build the shadow-page readback port.

module coef_bank #(
  parameter int DW = 36,
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          live,
  input  logic          wrEn,
  input  logic [AW:0]   wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic [AW:0]   rdAddr,
  output logic [DW-1:0] rdData
`ifdef COEF_RAM_READBACK_EN
  ,
  input  logic [AW:0]   rbAddr,
  output logic [DW-1:0] rbData
`endif
);
  // Both pages of one bank; the page bit is the address MSB.
  logic [DW-1:0] mem [2**(AW+1)];

  always_ff @(posedge clock)
    if (wrEn) mem[wrAddr] <= wrData;

  always_ff @(posedge clock or negedge reset)
    if (!reset)    rdData <= '0;
    else if (live) rdData <= mem[rdAddr];

`ifdef COEF_RAM_READBACK_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) rbData <= '0;
    else        rbData <= mem[rbAddr];
`endif
endmodule

module coef_pingpong_ram #(
  parameter int NCH   = 2,
  parameter int NBANK = 4,
  parameter int DW    = 36,
  parameter int AW    = 12,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LB   = $clog2(NBANK),
  localparam int HW   = AW + LB
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHW-1:0]           wr_ch,
  input  logic                     wr_load,
  input  logic [HW-1:0]            wr_addr,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
`ifdef COEF_RAM_READBACK_EN
  input  logic                     rb_en,
  input  logic [HW-1:0]            rb_addr,
  output logic [DW-1:0]            rb_data,
  output logic                     rb_valid,
`endif
  input  logic                     swap_req,
  input  logic                     frame_start,
  output logic                     swap_pending,
  output logic                     swap_ack,
  output logic                     act_page,
  input  logic [NCH*AW-1:0]        app_addr,
  output logic [NCH*NBANK*DW-1:0]  app_coef
);
  typedef enum logic {IDLE, ARMED} stateT;

  typedef struct packed {
    logic           en;
    logic [CHW-1:0] ch;
    logic [LB-1:0]  bank;
    logic [AW-1:0]  word;
    logic [DW-1:0]  data;
  } wrReqT;

  stateT  state, stateNx;
  logic   doSwap;
  logic   live;
  logic   [HW-1:0] wrPtr, effAddr;
  wrReqT  wrReq;
  logic   [NCH-1:0][NBANK-1:0][DW-1:0] appRd;

  // Inputs are ignored in the first cycle after reset release.
  always_ff @(posedge clock or negedge reset)
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;

  // A load in the same cycle as a write redirects that write to wr_addr.
  always_comb begin
    effAddr    = wr_load ? wr_addr : wrPtr;
    wrReq.en   = live & wr_en;
    wrReq.ch   = wr_ch;
    wrReq.bank = effAddr[LB-1:0];
    wrReq.word = effAddr[HW-1:LB];
    wrReq.data = wr_data;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) wrPtr <= '0;
    else if (live) begin
      if (wr_en)        wrPtr <= effAddr + 1'b1;
      else if (wr_load) wrPtr <= wr_addr;
    end

  always_comb begin
    stateNx = state;
    doSwap  = 1'b0;
    if (live) begin
      case (state)
        IDLE:  if (swap_req) begin
                 if (frame_start) doSwap  = 1'b1;
                 else             stateNx = ARMED;
               end
        ARMED: if (frame_start) begin
                 doSwap  = 1'b1;
                 stateNx = IDLE;
               end
        default: stateNx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      act_page <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      state    <= stateNx;
      act_page <= act_page ^ doSwap;
      swap_ack <= doSwap;
    end

  assign swap_pending = (state == ARMED);

`ifdef COEF_RAM_READBACK_EN
  logic [NCH-1:0][NBANK-1:0][DW-1:0] rbRd;
  logic [1:0]     vldPipe;
  logic [CHW-1:0] rbCh;
  logic [LB-1:0]  rbBank;

  // Stage 1 reads every bank of every channel; stage 2 picks channel and bank.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      vldPipe <= '0;
      rbCh    <= '0;
      rbBank  <= '0;
      rb_data <= '0;
    end else begin
      vldPipe <= {vldPipe[0], live & rb_en};
      rbCh    <= wr_ch;
      rbBank  <= rb_addr[LB-1:0];
      rb_data <= rbRd[rbCh][rbBank];
    end

  assign rb_valid = vldPipe[1];
`endif

  for (genvar c = 0; c < NCH; c++) begin : gCh
    for (genvar b = 0; b < NBANK; b++) begin : gBank
      coef_bank #(.DW(DW), .AW(AW)) uBank (
        .clock  (clock),
        .reset  (reset),
        .live   (live),
        .wrEn   (wrReq.en && (wrReq.ch == CHW'(c)) && (wrReq.bank == LB'(b))),
        .wrAddr ({~act_page, wrReq.word}),
        .wrData (wrReq.data),
        .rdAddr ({act_page, app_addr[c*AW +: AW]}),
        .rdData (appRd[c][b])
`ifdef COEF_RAM_READBACK_EN
        ,
        .rbAddr ({~act_page, rb_addr[HW-1:LB]}),
        .rbData (rbRd[c][b])
`endif
      );
    end
  end

  // Bank 0 occupies the MSBs of each channel slice.
  always_comb begin
    app_coef = '0;
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < NBANK; b++)
        app_coef[(c*NBANK + NBANK-1-b)*DW +: DW] = appRd[c][b];
  end
endmodule

// File: tb/tb_coef_pingpong_ram.sv
// Randomized bench for coef_pingpong_ram against a flat-array page/pointer model.
module tb_coef_pingpong_ram;
  localparam int NCH = 2, NBANK = 4, DW = 36, AW = 4;
  localparam int NW  = NBANK << AW;
  localparam int HW  = AW + 2;
  localparam int TOT = NCH*NBANK*DW;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [0:0]        wr_ch = '0;
  logic              wr_load = 1'b0;
  logic [HW-1:0]     wr_addr = '0;
  logic              wr_en = 1'b0;
  logic [DW-1:0]     wr_data = '0;
  logic              swap_req = 1'b0, frame_start = 1'b0;
  logic              swap_pending, swap_ack, act_page;
  logic [NCH*AW-1:0] app_addr = '0;
  logic [TOT-1:0]    app_coef;
`ifdef COEF_RAM_READBACK_EN
  logic              rb_en = 1'b0;
  logic [HW-1:0]     rb_addr = '0;
  logic [DW-1:0]     rb_data;
  logic              rb_valid;
`endif

  coef_pingpong_ram #(.NCH(NCH), .NBANK(NBANK), .DW(DW), .AW(AW)) dut (
    .clock(clock), .reset(reset), .wr_ch(wr_ch), .wr_load(wr_load), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data),
`ifdef COEF_RAM_READBACK_EN
    .rb_en(rb_en), .rb_addr(rb_addr), .rb_data(rb_data), .rb_valid(rb_valid),
`endif
    .swap_req(swap_req), .frame_start(frame_start), .swap_pending(swap_pending),
    .swap_ack(swap_ack), .act_page(act_page), .app_addr(app_addr), .app_coef(app_coef));

  always #5 clock = ~clock;

  int nVec = 0, nErr = 0;

  // Model: mem[channel][page][host address], host address low bits = bank.
  logic [DW-1:0]  mem [NCH][2][NW];
  int             mPtr;
  bit             mAct, mArmed, mAck, mLive;
  logic [TOT-1:0] eCoef;
  bit             rbV1, rbV2;
  logic [DW-1:0]  rbD1, rbD2;

  task automatic chk(input string tag, input logic [TOT-1:0] got, input logic [TOT-1:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    int eff;
    bit sw, vNew;
    logic [DW-1:0] dNew;
    vNew = 1'b0;
    dNew = '0;
    if (mLive) begin
      for (int c = 0; c < NCH; c++)
        for (int b = 0; b < NBANK; b++)
          eCoef[(c*NBANK + NBANK-1-b)*DW +: DW] = mem[c][mAct][int'(app_addr[c*AW +: AW])*NBANK + b];
`ifdef COEF_RAM_READBACK_EN
      vNew = rb_en;
      dNew = mem[wr_ch][~mAct][rb_addr];
`endif
      eff = wr_load ? int'(wr_addr) : mPtr;
      if (wr_en) begin
        mem[wr_ch][~mAct][eff] = wr_data;
        mPtr = (eff + 1) % NW;
      end else if (wr_load) mPtr = int'(wr_addr);
      sw     = frame_start && (mArmed || swap_req);
      mArmed = !sw && (mArmed || swap_req);
      mAct   = mAct ^ sw;
      mAck   = sw;
    end else mAck = 1'b0;
    rbV2 = rbV1; rbD2 = rbD1; rbV1 = vNew; rbD1 = dNew;
    mLive = 1'b1;
    @(posedge clock); #1;
    chk("act_page", act_page, mAct);
    chk("swap_pending", swap_pending, mArmed);
    chk("swap_ack", swap_ack, mAck);
    chk("app_coef", app_coef, eCoef);
`ifdef COEF_RAM_READBACK_EN
    chk("rb_valid", rb_valid, rbV2);
    if (rbV2) chk("rb_data", rb_data, rbD2);
    rb_en = 1'b0;
`endif
    wr_en = 1'b0; wr_load = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    wr_en = 1'b0; wr_load = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
`ifdef COEF_RAM_READBACK_EN
    rb_en = 1'b0;
`endif
    mAct = 0; mArmed = 0; mAck = 0; mPtr = 0; mLive = 0; eCoef = '0;
    rbV1 = 0; rbV2 = 0; rbD1 = '0; rbD2 = '0;
    #2;
    chk("rst_act", act_page, 0);
    chk("rst_pend", swap_pending, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_coef", app_coef, 0);
`ifdef COEF_RAM_READBACK_EN
    chk("rst_rbv", rb_valid, 0);
    chk("rst_rbd", rb_data, 0);
`endif
    @(posedge clock); #1;
    reset = 1'b1;
    step();  // first cycle after release: inputs ignored
  endtask

  task automatic swapNow();
    swap_req = 1'b1; frame_start = 1'b1;
    step();
  endtask

  logic [TOT-1:0] held;

  initial begin
    #1;
    doReset();

    // fill both pages of both channels so every read is defined
    for (int pg = 0; pg < 2; pg++) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ch = 1'(c);
        wr_load = 1'b1; wr_addr = '0;
        for (int i = 0; i < NW; i++) begin
          wr_en = 1'b1; wr_data = DW'({$urandom, $urandom});
          step();
        end
      end
      swapNow();
    end

    // basic fill, immediate swap, readout
    doReset();
    wr_ch = '0; wr_load = 1'b1; wr_addr = '0;
    step();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      step();
    end
    swapNow();
    chk("imm_swap_act", act_page, 1);
    chk("imm_swap_ack", swap_ack, 1);
    app_addr = '0;
    step();
    chk("coef_w0", app_coef[0 +: NBANK*DW], {36'd1, 36'd2, 36'd3, 36'd4});
    app_addr[AW-1:0] = AW'(1);
    step();
    chk("coef_w1", app_coef[0 +: NBANK*DW], {36'd5, 36'd6, 36'd7, 36'd8});

    // armed swap waits for frame_start
    swap_req = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) swap_req = 1'b1;
      step();
      chk("armed_pend", swap_pending, 1);
      chk("armed_act", act_page, 1);
    end
    frame_start = 1'b1;
    step();
    chk("fs_act", act_page, 0);
    chk("fs_pend", swap_pending, 0);
    chk("fs_ack", swap_ack, 1);
    frame_start = 1'b1;
    step();
    chk("idle_fs_act", act_page, 0);

    // pointer wrap from last word to bank 0 word 0
    wr_ch = '0; wr_load = 1'b1; wr_addr = HW'(NW - 1);
    step();
    wr_en = 1'b1; wr_data = DW'('hA); step();
    wr_en = 1'b1; wr_data = DW'('hB); step();
    swapNow();
    app_addr = '0; app_addr[AW-1:0] = AW'((1 << AW) - 1);
    step();
    chk("wrap_last", app_coef[0 +: DW], DW'('hA));
    app_addr = '0;
    step();
    chk("wrap_first", app_coef[(NBANK-1)*DW +: DW], DW'('hB));

    // shadow writes to ch1 must not disturb the filter view
    app_addr = NCH*AW'($urandom);
    step();
    held = eCoef;
    wr_ch = 1'b1; wr_load = 1'b1; wr_addr = HW'($urandom);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = DW'({$urandom, $urandom});
      step();
      chk("shadow_hold", app_coef, held);
    end
    swapNow();
    step();

    // reset while armed aborts the swap, RAM survives
    swap_req = 1'b1;
    step();
    chk("pre_rst_pend", swap_pending, 1);
    doReset();
    chk("post_rst_act", act_page, 0);
    chk("post_rst_pend", swap_pending, 0);
    for (int i = 0; i < 6; i++) begin
      app_addr = NCH*AW'($urandom);
`ifdef COEF_RAM_READBACK_EN
      rb_en = 1'b1; rb_addr = HW'($urandom); wr_ch = 1'($urandom);
`endif
      step();
    end
`ifdef COEF_RAM_READBACK_EN
    // readback of a word written in the same cycle returns old data
    wr_ch = '0; wr_load = 1'b1; wr_addr = HW'(5); wr_en = 1'b1; wr_data = DW'('h123);
    rb_en = 1'b1; rb_addr = HW'(5);
    step();
    rb_en = 1'b1; step();
    rb_en = 1'b1; step();
    step();
`endif

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) doReset();
      wr_ch       = 1'($urandom);
      wr_load     = ($urandom_range(0, 9) == 0);
      wr_addr     = HW'($urandom);
      wr_en       = 1'($urandom);
      wr_data     = DW'({$urandom, $urandom});
      swap_req    = ($urandom_range(0, 7) == 0);
      frame_start = ($urandom_range(0, 5) == 0);
      app_addr    = NCH*AW'($urandom);
`ifdef COEF_RAM_READBACK_EN
      rb_en       = 1'($urandom);
      rb_addr     = HW'($urandom);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/coef_pingpong_ram.md
COEF_PINGPONG_RAM -- requirements
Module: coef_pingpong_ram

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
 NCH, 2, number of filter channels (channel 0 = left, channel 1 = right).
 NBANK, 4, banks per page, a power of 2 >= 2.
 DW, 36, coefficient word width in bits.
 AW, 12, bank address width; depth per bank is 2^AW.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line, clock and reset first:
 clock  in  1  single clock; all logic on posedge.
 reset  in  1  asynchronous, active-low reset.
 wr_ch  in  clog2(NCH)  host channel select.
 wr_load  in  1  load the write pointer from wr_addr.
 wr_addr  in  AW+log2(NBANK)  host word address; the low log2(NBANK) bits select the bank.
 wr_en  in  1  write wr_data at the write pointer, then increment it.
 wr_data  in  DW  host write data.
 rb_en  in  1  readback request (RB_EN build only).
 rb_addr  in  AW+log2(NBANK)  readback address (RB_EN build only).
 rb_data  out  DW  readback data (RB_EN build only).
 rb_valid  out  1  rb_data qualifier (RB_EN build only).
 swap_req  in  1  one-cycle pulse requesting a page swap.
 frame_start  in  1  one-cycle filter frame boundary pulse.
 swap_pending  out  1  a swap is armed.
 swap_ack  out  1  one-cycle pulse in the cycle after a swap.
 act_page  out  1  page currently read by the filter.
 app_addr  in  NCH*AW  per-channel filter read address; channel c uses slice [c*AW +: AW].
 app_coef  out  NCH*NBANK*DW  per-channel coefficients; bank 0 is in the MSBs of each channel slice.

Function
REQ-003 Storage SHALL be NCH channels x 2 pages x NBANK banks x 2^AW words x DW bits; contents SHALL NOT be reset.
REQ-004 The host port SHALL write only the shadow page (~act_page) of channel wr_ch.
REQ-005 The write pointer SHALL be a single pointer shared by all channels and shall be updated as follows:
 wr_load: pointer <= wr_addr.
 wr_en: write at the pointer, then pointer <= pointer+1, wrapping from NBANK*2^AW-1 to 0.
 wr_load and wr_en in the same cycle: write at wr_addr, then pointer <= wr_addr+1.
REQ-006 app_coef SHALL be registered; data for app_addr presented at edge n SHALL appear after edge n+1 (latency 1); it SHALL always be read from act_page.
REQ-007 The swap FSM SHALL have two states, IDLE and ARMED; swap_pending SHALL be 1 exactly in ARMED.
REQ-008 The swap FSM SHALL make these transitions:
 IDLE + swap_req: go to ARMED.
 ARMED + frame_start: toggle act_page, return to IDLE, and pulse swap_ack in the next cycle.
REQ-009 swap_req and frame_start asserted in the same cycle while IDLE SHALL swap immediately, without passing through ARMED.
REQ-010 swap_req while ARMED SHALL be ignored; frame_start while IDLE SHALL have no effect.
REQ-011 A host write in the swap cycle SHALL target the pre-swap shadow page.
REQ-012 A host write and an app read of the same page are impossible by construction; there SHALL be no read-during-write hazard on the filter port.

Reset
REQ-013 While reset is low, the following SHALL hold: act_page=0, FSM in IDLE, swap_pending=0, swap_ack=0, write pointer=0, app_coef=0, rb_data=0, rb_valid=0.
REQ-014 Reset asserted mid-operation SHALL abort an armed swap with no page change; RAM contents SHALL be kept.
REQ-015 Reset release SHALL be synchronised by the integrator; the block SHALL sample no input in the first cycle after deassertion.

Configuration
REQ-016 Readback SHALL be controlled by macro COEF_RAM_READBACK_EN as follows:
 Defined: rb_data SHALL return the shadow-page word of channel wr_ch at rb_addr, 2 cycles after rb_en (bank-read register, then bank-select register), with rb_valid high in that same cycle.
 Defined, rb_en held: SHALL give one result per cycle.
 Defined, readback of the address written in the same cycle: SHALL return the old data.
 Not defined: the rb_* ports SHALL be absent and no readback RAM read ports SHALL be inferred.

Verification
REQ-017 Reset, then wr_load addr 0 and 8 wr_en writes 0x1..0x8 on ch0, then swap_req+frame_start, then app_addr ch0=0 and ch0=1: app_coef ch0 = {1,2,3,4} then {5,6,7,8}; swap_ack one cycle after.
REQ-018 swap_req, then 5 idle cycles, then frame_start: swap_pending high for those 5 cycles; act_page toggles only after frame_start; a second swap_req while pending has no extra effect.
REQ-019 wr_load addr NBANK*2^AW-1, then 2 writes 0xA, 0xB: 0xA lands in the last word of bank NBANK-1, and 0xB lands at bank 0 word 0.
REQ-020 Write ch1 shadow page while ch0/ch1 app reads run: app_coef unchanged until the swap; ch0 data unaffected.
REQ-021 Reset pulse while ARMED: act_page stays 0, swap_pending 0, and prior RAM contents are still readable via readback (RB_EN) after reset.
